// File: rtl/run_pkg.sv
// Shared types and defaults for the core run sequencer.
package run_pkg;

  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 8;
  localparam int CNT_W        = 16;
  localparam int RES_BASE_DEF = 64;
  localparam int RES_LEN_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DRAIN_RD,
    DRAIN_WAIT,
    DRAIN_OUT
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         saturated
);

  assign saturated = &count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !saturated) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Load / reset-hold / run / result-drain sequencer sitting in front of the core.
module core_run_ctrl
  import run_pkg::*;
#(
  parameter int            DW         = DATA_W,
  parameter int            AW         = ADDR_W,
  parameter int            CW         = CNT_W,
  parameter int            RST_CYCLES = 2,
  parameter logic [AW-1:0] RES_BASE   = AW'(RES_BASE_DEF),
  parameter logic [AW:0]   RES_LEN    = (AW+1)'(RES_LEN_DEF)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_reset,
  input  logic          core_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic [CW-1:0] cycle_count,
  output logic          timeout,
  output logic          finished
);

  localparam logic [AW:0] LAST_IDX = RES_LEN - (AW+1)'(1);

  run_state_t    state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW:0]   load_rem;
  logic [3:0]    hold_cnt;
  logic [AW:0]   idx, idx_nxt;
  logic [AW-1:0] rd_addr;
  logic          load_hs, out_hs;
  logic          cnt_clear, cnt_en, cnt_sat, set_timeout;

  assign load_hs = (state == LOAD) && in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;

  // Only the load writes are combinational; the drain read address is registered.
  assign mem_wr_en = load_hs;
  assign mem_addr  = (state == LOAD) ? addr : rd_addr;
  assign mem_wdata = (state == LOAD) ? in_data : '0;

  sat_counter #(.W(CW)) u_cycles (
    .clk       (Clk),
    .rst_n     (Reset),
    .clear     (cnt_clear),
    .enable    (cnt_en),
    .count     (cycle_count),
    .saturated (cnt_sat)
  );

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    set_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          idx_nxt   = '0;
          state_nxt = (load_len == '0) ? HOLD : LOAD;
        end
      end
      LOAD:       if (load_hs && load_rem == (AW+1)'(1)) state_nxt = HOLD;
      HOLD:       if (hold_cnt == 4'd0) state_nxt = RUN;
      RUN: begin
        cnt_en = 1'b1;
        // A done seen in the saturating cycle still counts as a clean finish.
        if (core_done) begin
          state_nxt = DRAIN_RD;
        end else if (cnt_sat) begin
          set_timeout = 1'b1;
          state_nxt   = DRAIN_RD;
        end
      end
      DRAIN_RD:   state_nxt = DRAIN_WAIT;
      DRAIN_WAIT: state_nxt = DRAIN_OUT;
      DRAIN_OUT: begin
        if (out_hs) begin
          idx_nxt   = idx + (AW+1)'(1);
          state_nxt = (idx == LAST_IDX) ? IDLE : DRAIN_RD;
        end
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      addr       <= '0;
      load_rem   <= '0;
      hold_cnt   <= '0;
      idx        <= '0;
      rd_addr    <= '0;
      in_ready   <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      mem_rd_en  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      timeout    <= 1'b0;
      finished   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      in_ready   <= (state_nxt == LOAD);
      core_reset <= (state_nxt != RUN);
      busy       <= (state_nxt != IDLE);
      mem_rd_en  <= (state_nxt == DRAIN_RD);
      rd_addr    <= (state_nxt == DRAIN_RD) ? RES_BASE + idx_nxt[AW-1:0] : '0;
      out_valid  <= (state_nxt == DRAIN_OUT);
      finished   <= (state == DRAIN_OUT) && (state_nxt == IDLE);
      if (state == IDLE && start) begin
        load_rem <= load_len;
        addr     <= '0;
        timeout  <= 1'b0;
      end
      if (load_hs) begin
        addr     <= addr + AW'(1);
        load_rem <= load_rem - (AW+1)'(1);
      end
      if (state_nxt == HOLD && state != HOLD) begin
        hold_cnt <= 4'(RST_CYCLES - 1);
      end else if (state == HOLD && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      if (set_timeout) timeout <= 1'b1;
      if (state == DRAIN_WAIT) out_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a byte memory and a core stand-in that raises Done after N run cycles.
module tb_core_run_ctrl;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic [8:0] load_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       core_reset;
  logic       core_done;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [3:0] cycle_count;
  logic       timeout;
  logic       finished;

  int checks = 0;
  int failures = 0;

  logic [7:0] memModel [256];
  int         runCycles;
  int         doneAfter;
  logic       doneEnable;

  logic [7:0] wrAddrQ [$];
  logic [7:0] wrDataQ [$];
  logic [7:0] drainedQ [$];
  int         rdCount;
  int         finCount;
  int         inReadySeen;
  int         holdCycles;
  logic       tracking;

  core_run_ctrl #(.CW(4)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .load_len    (load_len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .core_reset  (core_reset),
    .core_done   (core_done),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .cycle_count (cycle_count),
    .timeout     (timeout),
    .finished    (finished)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Synchronous byte memory: one-cycle read latency.
  always @(posedge Clk) begin
    if (mem_wr_en) memModel[mem_addr] = mem_wdata;
    if (mem_rd_en) mem_rdata <= memModel[mem_addr];
  end

  // Core stand-in: Done is raised during the doneAfter-th cycle out of reset.
  always @(posedge Clk) begin
    if (core_reset) runCycles <= 0;
    else            runCycles <= runCycles + 1;
  end
  assign core_done = doneEnable && !core_reset && (runCycles == doneAfter - 1);

  // Traffic log, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Reset) begin
      if (mem_wr_en) begin
        wrAddrQ.push_back(mem_addr);
        wrDataQ.push_back(mem_wdata);
        holdCycles = 0;
        tracking   = 1'b1;
      end else if (tracking) begin
        if (core_reset) holdCycles++;
        else            tracking = 1'b0;
      end
      if (mem_rd_en) rdCount++;
      if (out_valid && out_ready) drainedQ.push_back(out_data);
      if (finished) finCount++;
      if (in_ready) inReadySeen++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearLogs();
    wrAddrQ.delete();
    wrDataQ.delete();
    drainedQ.delete();
    rdCount     = 0;
    finCount    = 0;
    inReadySeen = 0;
    holdCycles  = 0;
    tracking    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [8:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitFinished(input int maxCycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      if (finished) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(seen), 32'd1);
    tick();
  endtask

  task automatic waitCoreRun(input int maxCycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (!core_reset && busy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  task automatic checkDrain(input string tag);
    checkOutput({tag, "_count"}, 32'(drainedQ.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] got;
      got = (i < drainedQ.size()) ? 32'(drainedQ[i]) : 32'hFFFF;
      checkOutput($sformatf("%s_byte%0d", tag, i), got, 32'(8'hA0 + i));
    end
  endtask

  initial begin
    logic [7:0] bytes [4];
    logic       pat [5];
    logic [7:0] held;
    logic       stable;

    Reset = 1'b0; start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; doneEnable = 1'b0; doneAfter = 10;
    for (int i = 0; i < 8; i++) memModel[64 + i] = 8'(8'hA0 + i);
    clearLogs();

    #22;
    checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    checkOutput("rst_cycle_count", 32'(cycle_count), 32'd0);
    checkOutput("rst_flags", {30'd0, timeout, finished}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    tick();

    $display("[TB] basic run");
    clearLogs();
    doneEnable = 1'b1; doneAfter = 10;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    applyStimulus(9'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = bytes[i];
      tick();
    end
    in_valid = 1'b0;
    waitFinished(200, "basic_finish");
    checkOutput("basic_wr_count", 32'(wrAddrQ.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("basic_wr_addr%0d", i), (i < wrAddrQ.size()) ? 32'(wrAddrQ[i]) : 32'hFFFF, 32'(i));
      checkOutput($sformatf("basic_wr_data%0d", i), (i < wrDataQ.size()) ? 32'(wrDataQ[i]) : 32'hFFFF, 32'(bytes[i]));
    end
    checkOutput("basic_hold_cycles", 32'(holdCycles), 32'd2);
    checkOutput("basic_cycle_count", 32'(cycle_count), 32'd10);
    checkOutput("basic_timeout", 32'(timeout), 32'd0);
    checkOutput("basic_fin_pulses", 32'(finCount), 32'd1);
    checkOutput("basic_rd_count", 32'(rdCount), 32'd8);
    checkDrain("basic_drain");

    $display("[TB] load stalls");
    clearLogs();
    doneAfter = 3;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
    applyStimulus(9'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = pat[i];
      in_data  = 8'(8'h50 + i);
      tick();
    end
    in_valid = 1'b0;
    waitFinished(200, "stall_finish");
    checkOutput("stall_wr_count", 32'(wrAddrQ.size()), 32'd3);
    checkOutput("stall_wr_addr2", (wrAddrQ.size() > 2) ? 32'(wrAddrQ[2]) : 32'hFFFF, 32'd2);
    checkOutput("stall_wr_data0", (wrDataQ.size() > 0) ? 32'(wrDataQ[0]) : 32'hFFFF, 32'h50);
    checkOutput("stall_wr_data1", (wrDataQ.size() > 1) ? 32'(wrDataQ[1]) : 32'hFFFF, 32'h53);
    checkOutput("stall_wr_data2", (wrDataQ.size() > 2) ? 32'(wrDataQ[2]) : 32'hFFFF, 32'h54);
    checkOutput("stall_cycle_count", 32'(cycle_count), 32'd3);

    $display("[TB] drain back-pressure");
    clearLogs();
    out_ready = 1'b0;
    applyStimulus(9'd0);
    for (int i = 0; i < 100 && !out_valid; i++) tick();
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    held   = out_data;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid || out_data !== held) stable = 1'b0;
    end
    checkOutput("bp_stable", 32'(stable), 32'd1);
    checkOutput("bp_first_byte", 32'(held), 32'hA0);
    checkOutput("bp_rd_during_stall", 32'(rdCount), 32'd1);
    checkOutput("bp_no_handshake", 32'(drainedQ.size()), 32'd0);
    out_ready = 1'b1;
    waitFinished(200, "bp_finish");
    checkOutput("bp_rd_count", 32'(rdCount), 32'd8);
    checkDrain("bp_drain");

    $display("[TB] timeout");
    clearLogs();
    doneEnable = 1'b0;
    applyStimulus(9'd0);
    waitFinished(300, "to_finish");
    checkOutput("to_cycle_count", 32'(cycle_count), 32'd15);
    checkOutput("to_timeout", 32'(timeout), 32'd1);
    checkOutput("to_drain_count", 32'(drainedQ.size()), 32'd8);
    doneEnable = 1'b1; doneAfter = 2;
    applyStimulus(9'd0);
    checkOutput("to_cleared_by_start", 32'(timeout), 32'd0);
    waitFinished(200, "to_rerun_finish");
    checkOutput("to_rerun_count", 32'(cycle_count), 32'd2);
    checkOutput("to_rerun_timeout", 32'(timeout), 32'd0);

    $display("[TB] reset mid-run");
    clearLogs();
    doneEnable = 1'b0;
    applyStimulus(9'd0);
    waitCoreRun(50, "mid_reach_run");
    for (int i = 0; i < 4; i++) tick();
    checkOutput("mid_count_before", 32'(cycle_count), 32'd4);
    Reset = 1'b0;
    #1;
    checkOutput("mid_core_reset", 32'(core_reset), 32'd1);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_cycle_count", 32'(cycle_count), 32'd0);
    tick(); tick();
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("mid_no_finish", 32'(finCount), 32'd0);
    checkOutput("mid_idle", 32'(busy), 32'd0);

    $display("[TB] zero-length load and start while busy");
    clearLogs();
    doneEnable = 1'b1; doneAfter = 6;
    applyStimulus(9'd0);
    waitCoreRun(50, "zl_reach_run");
    applyStimulus(9'd5);
    checkOutput("zl_still_busy", 32'(busy), 32'd1);
    waitFinished(200, "zl_finish");
    checkOutput("zl_cycle_count", 32'(cycle_count), 32'd6);
    checkOutput("zl_no_writes", 32'(wrAddrQ.size()), 32'd0);
    checkOutput("zl_no_in_ready", 32'(inReadySeen), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("zl_back_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
